axis_frame_len_check: RTL
=========================

Name: axis_frame_len_check

Overview:
- AXI-Stream frame length checker sitting directly upstream of the team's frame FIFO (the FIFO with tuser-based drop).
- Counts beats per frame, flags runt and oversize frames by asserting tuser on the last beat, so the downstream FIFO discards them.
- Oversize frames are truncated: a forced tlast is emitted at the max length, and the remaining input beats are swallowed.
- Single registered output stage; one clock, no internal storage beyond one beat.

Parameters:
- DATA_WIDTH, 8, tdata width in bits.
- LEN_WIDTH, 16, width of the beat counter and of the length config ports.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- cfg_min_len  input  LEN_WIDTH  minimum legal frame length in beats; 0 or 1 disables the runt check.
- cfg_max_len  input  LEN_WIDTH  maximum legal frame length in beats; 0 disables the oversize check.
- input_axis_tdata  input  DATA_WIDTH  input data.
- input_axis_tvalid  input  1  input valid.
- input_axis_tready  output  1  input ready.
- input_axis_tlast  input  1  input end of frame.
- input_axis_tuser  input  1  upstream bad-frame flag, sampled on the last beat.
- output_axis_tdata  output  DATA_WIDTH  output data.
- output_axis_tvalid  output  1  output valid.
- output_axis_tready  input  1  output ready.
- output_axis_tlast  output  1  output end of frame.
- output_axis_tuser  output  1  bad-frame flag, meaningful only with tlast.
- err_short  output  1  one-cycle pulse when a runt frame's last beat is accepted.
- err_long  output  1  one-cycle pulse when a forced tlast is generated.

Behaviour:
- Reset (rst=0, async): all output regs 0, state PASS, beat count 0, latched limits 0. Pulses cleared.
- Output register: input_axis_tready = (~output_axis_tvalid | output_axis_tready) in PASS; constant 1 in DISCARD.
- Latency: an accepted beat appears on the output the next cycle, or stalls in the register while output_axis_tready=0.
- Limit latching: cfg_min_len and cfg_max_len are latched on the first accepted beat of each frame (count==0). Mid-frame config changes have no effect until the next frame.
- Beat count n: incremented per accepted beat, saturating at 2^LEN_WIDTH-1. It is the count including the current beat.
- PASS, non-last beat:
  - If max!=0 and n==max: the output beat gets tlast=1 and tuser=1, err_long pulses, n resets to 0, and the state goes to DISCARD.
  - Otherwise the beat passes unchanged with tlast=0 and tuser=0.
- PASS, last beat (input tlast=1):
  - tuser_out = input tuser | (min>1 & n<min) | (max!=0 & n>max).
  - err_short pulses if n<min and min>1.
  - n resets to 0; the state stays PASS.
- A last beat arriving exactly at n==max is legal. It passes with tlast=1 and tuser = input tuser only; no forced tlast and no DISCARD.
- DISCARD: input beats are accepted (ready=1) and dropped, with nothing output. On an accepted beat with tlast=1 the state returns to PASS and n=0.
- Output register contents: accepted in DISCARD never load it; a pending forced-tlast beat in the register stalls normally.
- Simultaneous output and input handshake in PASS: the register updates in the same cycle, giving full throughput of 1 beat/cycle.
- Single-beat frame (tlast on first beat): n=1; it is a runt if min>1.
- Saturation: if max=0 and the frame exceeds 2^LEN_WIDTH-1 beats, n holds at the saturated value. No error is raised unless min exceeds it (impossible).
- Reset mid-frame: the partial frame is lost, and the output returns to idle immediately.

Optional Feature:
- Macro: AXIS_LEN_CHECK_STATS_EN.
- Defined: adds three outputs, each 32 bits, saturating, reset 0:
  - stat_good_frames, incremented per emitted tlast with tuser=0.
  - stat_short_frames, incremented per err_short.
  - stat_long_frames, incremented per err_long.
- Not defined: these ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package axis_pkg:
  - state encoding typedef (PASS=0, DISCARD=1);
  - localparam for the stats counter width (32).
- One natural sub-module: axis_out_reg, the single-entry output register with the valid/ready handshake (carries tdata/tlast/tuser). The checker instantiates it.

Test Plan:
- min=4, max=8; 6-beat frame, tuser=0, tready=1 -> 6 beats out at 1-cycle latency, tlast on beat 6, tuser=0, no pulses.
- min=4, max=8; 2-beat frame -> 2 beats out, tlast on beat 2 with tuser=1, err_short pulses once.
- min=4, max=8; 12-beat frame -> 8 beats out, beat 8 has tlast=1 and tuser=1, err_long pulses once; beats 9-12 dropped with tready=1; the next frame passes normally.
- min=0, max=8; 8-beat frame with input tuser=1 on the last beat -> 8 beats out, tlast on beat 8, tuser=1, no pulses.
- Random output_axis_tready backpressure (50%) on back-to-back 5-beat frames, min=4, max=8 -> data order preserved, no loss or duplication, tuser=0 throughout.
- rst=0 asserted mid-frame with output stalled -> tvalid=0 asynchronously; after release a fresh 4-beat frame passes with n counted from 1. With AXIS_LEN_CHECK_STATS_EN defined, all stats read 0 after reset.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared types for the AXI-Stream frame length checker.
package axis_pkg;

  typedef enum logic {
    ST_PASS    = 1'b0,
    ST_DISCARD = 1'b1
  } state_e;

  localparam int unsigned STAT_WIDTH = 32;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register: loads when empty or draining, full throughput.
module axis_out_reg #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_last_i,
  input  logic                  in_user_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic                  out_user_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  last_q;
  logic                  user_q;
  logic                  load;

  assign in_ready_o = ~valid_q | out_ready_i;
  assign load       = in_valid_i & in_ready_o;
  assign valid_d    = load | (valid_q & ~out_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        data_q <= in_data_i;
        last_q <= in_last_i;
        user_q <= in_user_i;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;
  assign out_user_o  = user_q;

endmodule

// File: rtl/axis_frame_len_check.sv
// AXI-Stream frame length checker: flags runts, truncates oversize frames with a forced tlast.
// Optional statistics counters are enabled by defining AXIS_LEN_CHECK_STATS_EN.
module axis_frame_len_check
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_WIDTH-1:0]  cfg_min_len,
  input  logic [LEN_WIDTH-1:0]  cfg_max_len,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  output_axis_tuser,
`ifdef AXIS_LEN_CHECK_STATS_EN
  output logic [STAT_WIDTH-1:0] stat_good_frames,
  output logic [STAT_WIDTH-1:0] stat_short_frames,
  output logic [STAT_WIDTH-1:0] stat_long_frames,
`endif
  output logic                  err_short,
  output logic                  err_long
);

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] min_q, min_d;
  logic [LEN_WIDTH-1:0] max_q, max_d;
  logic                 err_short_q, err_short_d;
  logic                 err_long_q, err_long_d;

  logic                 reg_ready;
  logic                 accept;
  logic                 beat_valid;
  logic                 beat_last;
  logic                 beat_user;
  logic [LEN_WIDTH-1:0] n;
  logic [LEN_WIDTH-1:0] lim_min;
  logic [LEN_WIDTH-1:0] lim_max;
  logic                 runt;
  logic                 over;
  logic                 hit_max;

  assign input_axis_tready = (state_q == ST_DISCARD) | reg_ready;
  assign accept            = input_axis_tvalid & input_axis_tready;

  // Limits come straight from the config ports on a frame's first beat, so the
  // latched copy is only consulted from the second beat onwards.
  assign lim_min = (cnt_q == '0) ? cfg_min_len : min_q;
  assign lim_max = (cnt_q == '0) ? cfg_max_len : max_q;
  assign n       = (cnt_q == '1) ? cnt_q : cnt_q + LEN_WIDTH'(1);
  assign runt    = (lim_min > LEN_WIDTH'(1)) & (n < lim_min);
  assign over    = (lim_max != '0) & (n > lim_max);
  assign hit_max = (lim_max != '0) & (n == lim_max);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    min_d       = min_q;
    max_d       = max_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    beat_valid  = 1'b0;
    beat_last   = 1'b0;
    beat_user   = 1'b0;
    case (state_q)
      ST_PASS: begin
        beat_valid = input_axis_tvalid;
        if (!input_axis_tlast && hit_max) begin
          beat_last = 1'b1;
          beat_user = 1'b1;
        end else if (input_axis_tlast) begin
          beat_last = 1'b1;
          beat_user = input_axis_tuser | runt | over;
        end
        if (accept) begin
          if (cnt_q == '0) begin
            min_d = cfg_min_len;
            max_d = cfg_max_len;
          end
          if (!input_axis_tlast && hit_max) begin
            err_long_d = 1'b1;
            cnt_d      = '0;
            state_d    = ST_DISCARD;
          end else if (input_axis_tlast) begin
            err_short_d = runt;
            cnt_d       = '0;
          end else begin
            cnt_d = n;
          end
        end
      end
      ST_DISCARD: begin
        if (accept && input_axis_tlast) begin
          state_d = ST_PASS;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_PASS;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_PASS;
      cnt_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      min_q       <= min_d;
      max_q       <= max_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
    end
  end

  assign err_short = err_short_q;
  assign err_long  = err_long_q;

  axis_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk_i      (clk),
    .rst_ni     (rst),
    .in_valid_i (beat_valid),
    .in_ready_o (reg_ready),
    .in_data_i  (input_axis_tdata),
    .in_last_i  (beat_last),
    .in_user_i  (beat_user),
    .out_valid_o(output_axis_tvalid),
    .out_ready_i(output_axis_tready),
    .out_data_o (output_axis_tdata),
    .out_last_o (output_axis_tlast),
    .out_user_o (output_axis_tuser)
  );

`ifdef AXIS_LEN_CHECK_STATS_EN
  logic [STAT_WIDTH-1:0] good_q, short_q, long_q;
  logic                  good_evt;

  assign good_evt = output_axis_tvalid & output_axis_tready & output_axis_tlast & ~output_axis_tuser;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      good_q  <= '0;
      short_q <= '0;
      long_q  <= '0;
    end else begin
      if (good_evt && good_q != '1)     good_q  <= good_q + STAT_WIDTH'(1);
      if (err_short_q && short_q != '1) short_q <= short_q + STAT_WIDTH'(1);
      if (err_long_q && long_q != '1)   long_q  <= long_q + STAT_WIDTH'(1);
    end
  end

  assign stat_good_frames  = good_q;
  assign stat_short_frames = short_q;
  assign stat_long_frames  = long_q;
`endif

endmodule
